mc_sequencer: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back over several cycles instead of one. It shares a single memory port between instruction fetch and LW/SW data access. It gates PC, IR, register-file and memory enables, and halts on illegal opcodes or memory timeouts. The existing combinational decoder keeps producing the datapath selects, and this block decides in which cycle they take effect.

---
 rtl/mc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a shared memory port, and halts on an illegal opcode or a memory timeout.
`timescale 1ns/1ps
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        pc_w_en,
    output logic        pc_br_en,
    output logic        pc_jmp_en,
    output logic        rf_commit,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BOOT   = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_BR, C_JMP, C_ALU, C_LD, C_ST
    } op_class_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t c;
        casez (op)
            6'b000001, 6'b0001??:                       c = C_BR;
            6'b00001?:                                  c = C_JMP;
            6'b000000, 6'b001???, 6'b011100, 6'b011111: c = C_ALU;
            6'b100011:                                  c = C_LD;
            6'b101011:                                  c = C_ST;
            default:                                    c = C_ILL;
        endcase
        return c;
    endfunction

    state_t          cur_state;
    state_t          next_state;
    op_class_t       op_class;
    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;
    logic [1:0]      halt_next;
    logic            unused_ir;

    assign unused_ir = ^ir[25:0];
    assign op_class  = classify(ir[31:26]);
    assign state     = cur_state;

    // Only meaningful while a request is outstanding; ready in the last cycle still wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_BOOT;
        else        cur_state <= next_state;
    end

    always_comb begin
        next_state   = cur_state;
        halt_next    = 2'b00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_w_en      = 1'b0;
        pc_br_en     = 1'b0;
        pc_jmp_en    = 1'b0;
        rf_commit    = 1'b0;
        halted       = 1'b0;
        case (cur_state)
            S_BOOT: next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_w_en    = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                    halt_next  = 2'b10;
                end
            end
            S_DECODE: begin
                if (op_class == C_ILL) begin
                    next_state = S_HALT;
                    halt_next  = 2'b01;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_class)
                    C_BR: begin
                        pc_br_en   = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_JMP: begin
                        pc_jmp_en  = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_ALU:       next_state = S_WB;
                    C_LD, C_ST:  next_state = S_MEM;
                    default: begin
                        next_state = S_HALT;
                        halt_next  = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_class == C_ST);
                if (mem_ready) begin
                    next_state = (op_class == C_LD) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                    halt_next  = 2'b10;
                end
            end
            S_WB: begin
                rf_commit  = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: next_state = S_BOOT;
        endcase
    end

    // Counter idles at zero whenever no request is pending, so every entry to FETCH/MEM starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wait_cnt <= '0;
        else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
        else                            wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (next_state == S_FETCH &&
                     (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB)) begin
            instret <= instret + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_cause <= 2'b00;
        end else if (next_state == S_HALT && cur_state != S_HALT) begin
            halt_cause <= halt_next;
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: expands each instruction into its expected per-cycle trace
// from the class/latency rules and compares every cycle against the DUT.
`timescale 1ns/1ps
module tb_mc_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_w_en;
    logic        pc_br_en, pc_jmp_en, rf_commit, halted;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] instret;

    mc_sequencer #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_load(ir_load), .pc_w_en(pc_w_en), .pc_br_en(pc_br_en),
        .pc_jmp_en(pc_jmp_en), .rf_commit(rf_commit), .state(state),
        .halted(halted), .halt_cause(halt_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    // Flag bits: req, we, sel, ir_load, pc_w_en, br, jmp, commit, halted
    localparam logic [8:0] REQ = 9'h100, WE = 9'h080, SEL = 9'h040, IRL = 9'h020, PCW = 9'h010;
    localparam logic [8:0] BR  = 9'h008, JMP = 9'h004, COM = 9'h002, HLT = 9'h001;

    localparam logic [31:0] I_ADDU = 32'h0043_0821;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    typedef struct packed {
        logic [2:0]  st;
        logic [8:0]  fl;
        logic [1:0]  cause;
        logic        rdy;
        logic [31:0] irv;
        logic [31:0] ins;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    bit          cur_vld = 1'b0;
    logic [31:0] m_ins;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // 0 illegal, 1 branch, 2 jump, 3 alu, 4 load, 5 store
    function automatic int cls(input logic [5:0] op);
        int o = int'(op);
        if (o == 1 || (o >> 2) == 1) return 1;
        if ((o >> 1) == 1) return 2;
        if (o == 0 || (o >> 3) == 1 || o == 28 || o == 31) return 3;
        if (o == 35) return 4;
        if (o == 43) return 5;
        return 0;
    endfunction

    function automatic void add(input logic [2:0] st, input logic [8:0] fl, input logic [1:0] cause,
                                input logic rdy, input logic [31:0] irv);
        rec_t r;
        r.st = st; r.fl = fl; r.cause = cause; r.rdy = rdy; r.irv = irv; r.ins = m_ins;
        q.push_back(r);
    endfunction

    function automatic void halt_tail(input logic [1:0] cause);
        for (int k = 0; k < 20; k++) add(3'd7, HLT, cause, 1'($urandom), $urandom);
    endfunction

    // w stall cycles then completion; TO stalls in a row end in a halt.
    function automatic bit mem_phase(input logic [2:0] st, input int w, input logic [8:0] fl,
                                     input logic [8:0] done_fl, input logic [31:0] irv);
        int stalls = (TO != 0 && w >= TO) ? TO : w;
        for (int k = 0; k < stalls; k++) add(st, fl, 2'b00, 1'b0, irv);
        if (TO != 0 && w >= TO) return 1'b0;
        add(st, fl | done_fl, 2'b00, 1'b1, irv);
        return 1'b1;
    endfunction

    function automatic bit instr(input logic [31:0] iw, input int wf, input int wm);
        int c = cls(iw[31:26]);
        if (!mem_phase(3'd0, wf, REQ, IRL | PCW, $urandom)) begin
            halt_tail(2'b10);
            return 1'b0;
        end
        add(3'd1, 9'h0, 2'b00, 1'($urandom), iw);
        if (c == 0) begin
            halt_tail(2'b01);
            return 1'b0;
        end
        add(3'd2, (c == 1) ? BR : (c == 2) ? JMP : 9'h0, 2'b00, 1'($urandom), iw);
        if (c == 4 || c == 5) begin
            if (!mem_phase(3'd3, wm, REQ | SEL | ((c == 5) ? WE : 9'h0), 9'h0, iw)) begin
                halt_tail(2'b10);
                return 1'b0;
            end
        end
        if (c == 3 || c == 4) add(3'd4, COM, 2'b00, 1'($urandom), $urandom);
        m_ins = m_ins + 32'd1;
        return 1'b1;
    endfunction

    function automatic void start_ep();
        q.delete();
        m_ins = 32'd0;
        add(3'd5, 9'h0, 2'b00, 1'($urandom), $urandom);
    endfunction

    task automatic run_ep(input int upto);
        for (int i = 0; i < upto && i < q.size(); i++) begin
            cur       = q[i];
            mem_ready = cur.rdy;
            ir        = cur.irv;
            rst_n     = 1'b1;
            cur_vld   = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        cur_vld = 1'b0;
    endtask

    task automatic do_reset();
        cur_vld   = 1'b0;
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({state, mem_req, mem_we, mem_addr_sel, ir_load, pc_w_en, pc_br_en, pc_jmp_en,
                 rf_commit, halted, halt_cause}),
            64'({3'd5, 9'h0, 2'b00}));
        chk("reset_instret", 64'(instret), 64'd0);
    endtask

    always @(negedge clk) begin
        if (cur_vld) begin
            chk("cycle_outputs",
                64'({state, mem_req, mem_we, mem_addr_sel, ir_load, pc_w_en, pc_br_en, pc_jmp_en,
                     rf_commit, halted, halt_cause}),
                64'({cur.st, cur.fl, cur.cause}));
            chk("cycle_instret", 64'(instret), 64'(cur.ins));
        end
    end

    initial begin
        int          exp_st [6] = '{5, 0, 1, 2, 4, 0};
        logic [5:0]  ops [12] = '{6'd0, 6'd1, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8, 6'd15, 6'd28, 6'd31, 6'd35, 6'd43};
        bit          ok;
        logic [5:0]  op;
        int          r, wf, wm;

        // ADDU, LW (2 waits), SW, BEQ, J with zero-wait fetches
        do_reset();
        start_ep();
        ok = instr(I_ADDU, 0, 0);
        ok = instr(I_LW, 0, 2);
        ok = instr(I_SW, 0, 0);
        ok = instr(I_BEQ, 0, 0);
        ok = instr(I_J, 0, 0);
        chk("model_len_mix", 64'(q.size()), 64'd22);
        for (int i = 0; i < 6; i++) chk("model_addu_state", 64'(q[i].st), 64'(exp_st[i]));
        chk("model_addu_ret", 64'(q[5].ins), 64'd1);
        chk("model_lw_wb_idx", 64'(q[11].st), 64'd4);
        chk("model_ret_total", 64'(m_ins), 64'd5);
        run_ep(q.size());
        chk("instret_after_mix", 64'(instret), 64'd5);
        chk("state_after_mix", 64'(state), 64'd0);

        // Illegal opcode
        do_reset();
        start_ep();
        ok = instr(I_ADDU, 0, 0);
        ok = instr(I_BAD, 0, 0);
        chk("model_len_illegal", 64'(q.size()), 64'd27);
        chk("model_illegal_cause", 64'(q[q.size()-1].cause), 64'd1);
        run_ep(q.size());
        chk("illegal_halt_hold", 64'({halted, halt_cause, instret}), 64'({1'b1, 2'b01, 32'd1}));

        // Fetch timeout: ready stuck low
        do_reset();
        start_ep();
        ok = instr(I_ADDU, 0, 0);
        ok = instr(I_ADDU, TO, 0);
        chk("model_len_fetch_to", 64'(q.size()), 64'd29);
        chk("model_fetch_to_halt", 64'({q[9].st, q[9].cause}), 64'({3'd7, 2'b10}));
        run_ep(q.size());

        // Ready in the last legal memory cycle: no halt
        do_reset();
        start_ep();
        ok = instr(I_LW, 0, TO - 1);
        ok = instr(I_ADDU, 0, 0);
        chk("model_len_last_ready", 64'(q.size()), 64'd13);
        run_ep(q.size());
        chk("last_ready_no_halt", 64'({halted, instret}), 64'({1'b0, 32'd2}));

        // Data-phase timeout on a store
        do_reset();
        start_ep();
        ok = instr(I_SW, 1, TO);
        chk("model_len_mem_to", 64'(q.size()), 64'd29);
        run_ep(q.size());

        // Asynchronous reset in the middle of a stalled MEM
        do_reset();
        start_ep();
        ok = instr(I_ADDU, 0, 0);
        ok = instr(I_LW, 0, 3);
        run_ep(9);
        chk("mid_mem_before", 64'({state, mem_req, mem_addr_sel, instret}), 64'({3'd3, 1'b1, 1'b1, 32'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_mem_async_drop",
            64'({state, mem_req, mem_addr_sel, halted, halt_cause, instret}),
            64'({3'd5, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0}));

        // Randomized instruction streams
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            start_ep();
            for (int n = 0; n < 30; n++) begin
                op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
                r  = int'($urandom_range(0, 19));
                wf = (r < 17) ? r % 4 : TO + r - 17;
                r  = int'($urandom_range(0, 19));
                wm = (r < 17) ? r % 4 : TO + r - 17;
                if (!instr({op, 26'($urandom)}, wf, wm)) break;
            end
            run_ep(q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
